next_pc_unit: RTL

Registered program-counter stage for the single-cycle RISC-V core. Each cycle it picks the next PC from sequential, branch-offset and ALU (JALR) targets and holds the PC register. It adds stall support and a one-entry pending-redirect buffer so a taken branch seen during a stall is not lost. An optional trap path supports misaligned-target detection. It sits between the branch selector and the instruction memory address port.

---
 rtl/next_pc_unit_if.sv | 36 +++
 rtl/next_pc_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/next_pc_unit_if.sv
// Next-PC bus between branch selector, PC stage and imem address port.
// Ports: stall/OutputSelector/PCoffset/PCALU in, pc/PC4/redirect_pending out; trap set with NEXT_PC_TRAP_EN.
interface next_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [1:0]      OutputSelector;
  logic [XLEN-1:0] PCoffset;
  logic [XLEN-1:0] PCALU;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] PC4;
  logic            redirect_pending;
`ifdef NEXT_PC_TRAP_EN
  logic            trap_req;
  logic [XLEN-1:0] trap_vec;
  logic            misalign;
`endif

  modport master (
    output stall, OutputSelector, PCoffset, PCALU,
`ifdef NEXT_PC_TRAP_EN
    output trap_req, trap_vec,
    input  misalign,
`endif
    input  pc, PC4, redirect_pending
  );

  modport slave (
    input  stall, OutputSelector, PCoffset, PCALU,
`ifdef NEXT_PC_TRAP_EN
    input  trap_req, trap_vec,
    output misalign,
`endif
    output pc, PC4, redirect_pending
  );
endinterface

// File: rtl/next_pc_unit.sv
// Registered PC stage: picks PC+4/branch/JALR target, stalls, buffers one redirect.
// Ports: clk, rst (async active-low), bus (slave). Optional trap path: NEXT_PC_TRAP_EN.
module next_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  next_pc_unit_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pc4, cand, tgt;
  logic            redir, load;
`ifdef NEXT_PC_TRAP_EN
  logic            mis_q, mis_d;
`endif

  always_comb begin
    pc4 = pc_q + XLEN'(4);
    cand = pc4;
    unique case (1'b1)
      bus.OutputSelector == 2'b01: cand = bus.PCoffset;
      bus.OutputSelector == 2'b10: cand = bus.PCALU & ~XLEN'(1);
      default:                     cand = pc4;
    endcase
    redir = (bus.OutputSelector == 2'b01) ||
            (bus.OutputSelector == 2'b10);
  end

  always_comb begin
    pc_d   = pc_q;
    buf_d  = buf_q;
    pend_d = pend_q;
    load   = 1'b0;
    tgt    = cand;
`ifdef NEXT_PC_TRAP_EN
    mis_d  = 1'b0;
`endif
    // A buffered redirect owns the first free cycle.
    if (!bus.stall && pend_q) begin
      load   = 1'b1;
      tgt    = buf_q;
      pend_d = 1'b0;
    end else if (bus.stall) begin
      if (redir && !pend_q) begin
        buf_d  = cand;
        pend_d = 1'b1;
      end
    end else begin
      load = 1'b1;
    end
`ifdef NEXT_PC_TRAP_EN
    if (load) begin
      if (tgt[1]) begin
        pc_d  = bus.trap_vec;
        mis_d = 1'b1;
      end else begin
        pc_d = tgt;
      end
    end
    if (bus.trap_req) begin
      pc_d   = bus.trap_vec;
      pend_d = 1'b0;
      mis_d  = 1'b0;
    end
`else
    if (load) pc_d = tgt & ~XLEN'(3);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      buf_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      buf_q  <= buf_d;
      pend_q <= pend_d;
    end
  end

`ifdef NEXT_PC_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end
  assign bus.misalign = mis_q;
`endif

  assign bus.pc               = pc_q;
  assign bus.PC4              = pc4;
  assign bus.redirect_pending = pend_q;

endmodule
